// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU mode encoding and RMW sequencer state types
package cpu_pkg;

  typedef enum logic [4:0] {
    ADC = 5'd0,
    AND = 5'd1,
    ORA = 5'd2,
    EOR = 5'd3,
    SBC = 5'd4,
    ASL = 5'd5,
    ROL = 5'd6,
    LSR = 5'd7,
    ROR = 5'd8,
    INC = 5'd9,
    DEC = 5'd10
  } alu_mode_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_DUMMY_WR = 3'd2,
    S_EXEC     = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } rmw_state_t;

  // True for the memory ops this sequencer knows how to run
  function automatic logic is_rmw_op(alu_mode_t m);
    case (m)
      ASL, ROL, LSR, ROR, INC, DEC: is_rmw_op = 1'b1;
      default:                      is_rmw_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rmw_sequencer.sv
// rtl/rmw_sequencer.sv - read-modify-write sequencer for 6502 memory shift/rotate/inc/dec
module rmw_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter bit DUMMY_WRITE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              c_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [4:0]        alu_mode,
  output logic              alu_carry_in,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry_out,
  output logic              flags_we,
  output logic              c_we,
  output logic              n_out,
  output logic              z_out,
  output logic              c_out
);

  rmw_state_t        state_q, state_d;
  alu_mode_t         op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cin_q;
  logic              err_q;
  logic [7:0]        operand_q;
  logic [7:0]        result_q;
  logic              cy_q;
  logic              is_shift;

  assign is_shift = (op_q == ASL) || (op_q == ROL) || (op_q == LSR) || (op_q == ROR);

  // State register; reset returns to IDLE so bus requests drop at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance on bus completion, EXEC and DONE last one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_rmw_op(alu_mode_t'(op)) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          state_d = DUMMY_WRITE ? S_DUMMY_WR : S_EXEC;
        end
      end
      S_DUMMY_WR: begin
        if (mem_ready) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: begin
        if (mem_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture request, read operand, and ALU result/carry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= ADC;
      addr_q    <= '0;
      cin_q     <= 1'b0;
      err_q     <= 1'b0;
      operand_q <= 8'h00;
      result_q  <= 8'h00;
      cy_q      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        op_q   <= alu_mode_t'(op);
        addr_q <= addr;
        cin_q  <= c_in;
        err_q  <= !is_rmw_op(alu_mode_t'(op));
      end
      if (state_q == S_READ && mem_ready) begin
        operand_q <= mem_rdata;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_out;
        cy_q     <= alu_carry_out;
      end
    end
  end

  // Outputs decoded from state; INC/DEC borrow the ADC/SBC datapath
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    err          = 1'b0;
    mem_addr     = addr_q;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = 8'h00;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_mode     = 5'd0;
    alu_carry_in = 1'b0;
    flags_we     = 1'b0;
    c_we         = 1'b0;
    n_out        = 1'b0;
    z_out        = 1'b0;
    c_out        = 1'b0;
    case (state_q)
      S_READ: mem_rd = 1'b1;
      S_DUMMY_WR: begin
        mem_wr    = 1'b1;
        mem_wdata = operand_q;
      end
      S_EXEC: begin
        alu_a = operand_q;
        if (op_q == INC) begin
          alu_mode     = ADC;
          alu_b        = 8'h01;
          alu_carry_in = 1'b0;
        end else if (op_q == DEC) begin
          alu_mode     = SBC;
          alu_b        = 8'h01;
          alu_carry_in = 1'b1;
        end else begin
          alu_mode     = op_q;
          alu_carry_in = cin_q;
        end
      end
      S_WRITE: begin
        mem_wr    = 1'b1;
        mem_wdata = result_q;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
        if (!err_q) begin
          flags_we = 1'b1;
          n_out    = result_q[7];
          z_out    = (result_q == 8'h00);
          c_we     = is_shift;
          c_out    = is_shift ? cy_q : 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rmw_sequencer.sv
// tb/tb_rmw_sequencer.sv - self-checking bench for rmw_sequencer
module tb_rmw_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  op;
  logic [15:0] addr;
  logic        c_in;
  logic        busy, done, err;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic [7:0]  alu_a, alu_b;
  logic [4:0]  alu_mode;
  logic        alu_carry_in;
  logic [7:0]  alu_out;
  logic        alu_carry_out;
  logic        flags_we, c_we, n_out, z_out, c_out;

  rmw_sequencer #(.ADDR_W(16), .DUMMY_WRITE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .c_in(c_in),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_out(alu_out), .alu_carry_out(alu_carry_out),
    .flags_we(flags_we), .c_we(c_we), .n_out(n_out), .z_out(z_out), .c_out(c_out)
  );

  always #5 clk = ~clk;

  // 6502-style ALU stand-in
  always_comb begin
    {alu_carry_out, alu_out} = 9'h000;
    case (alu_mode)
      ADC: {alu_carry_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      SBC: {alu_carry_out, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_carry_in};
      ASL: {alu_carry_out, alu_out} = {alu_a, 1'b0};
      ROL: {alu_carry_out, alu_out} = {alu_a, alu_carry_in};
      LSR: {alu_out, alu_carry_out} = {1'b0, alu_a};
      ROR: {alu_out, alu_carry_out} = {alu_carry_in, alu_a};
      default: ;
    endcase
  end

  typedef struct {
    alu_mode_t   op;
    logic [15:0] addr;
    logic [7:0]  val;
    logic        cin;
    int          rdw, dww, ww;
    logic [7:0]  res;
    logic        n, z, c, cwe;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_q[$];
  logic [15:0] exp_addr = 16'h0;
  logic exp_n, exp_z, exp_c, exp_cwe, exp_err;
  int   exp_done_cyc = 0;
  int   edge_cnt = 0, start_edge = 0, last_done_cyc = 0;
  int   rd_wait = 0, dwr_wait = 0, wr_wait = 0, wr_idx = 0, stall_cnt = 0;
  bit   in_op = 0, done_seen = 0, hold_rd = 0, hold_wr = 0;
  logic [7:0] hold_data = 8'h00;
  logic obs_n, obs_z, obs_c, obs_cwe;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit legal(input alu_mode_t m);
    return m inside {ASL, ROL, LSR, ROR, INC, DEC};
  endfunction

  // Architectural effect of each op on a memory byte
  task automatic model(input alu_mode_t m, input int v, input int ci,
                       output int r, output int c, output bit cwe);
    r = v; c = 0; cwe = 1;
    case (m)
      ASL: begin r = (v * 2) % 256;      c = (v >= 128) ? 1 : 0; end
      ROL: begin r = (v * 2) % 256 + ci; c = (v >= 128) ? 1 : 0; end
      LSR: begin r = v / 2;              c = v % 2; end
      ROR: begin r = v / 2 + ci * 128;   c = v % 2; end
      INC: begin r = (v + 1) % 256;      cwe = 0; end
      DEC: begin r = (v + 255) % 256;    cwe = 0; end
      default: cwe = 0;
    endcase
  endtask

  always @(posedge clk) edge_cnt++;

  // Bus responder plus per-cycle comparison against the model
  always @(negedge clk) begin
    int cyc;
    int wlim;
    logic [7:0] e;
    cyc = edge_cnt - start_edge + 1;
    if (reset) begin
      mem_ready = 1'b0;
    end else if (mem_rd) begin
      if (stall_cnt < rd_wait) begin mem_ready = 1'b0; stall_cnt++; end
      else begin mem_ready = 1'b1; mem_rdata = mem[mem_addr]; stall_cnt = 0; end
    end else if (mem_wr) begin
      wlim = (wr_idx == 0) ? dwr_wait : wr_wait;
      if (stall_cnt < wlim) begin mem_ready = 1'b0; stall_cnt++; end
      else begin mem_ready = 1'b1; stall_cnt = 0; end
    end else begin
      mem_ready = 1'b0;
    end

    if (!reset) begin
      check(!(mem_rd && mem_wr), "rd_wr_overlap", {mem_rd, mem_wr}, 0);
      check(busy == in_op, "busy", busy, in_op);
      if (hold_rd) check(mem_rd == 1'b1, "rd_hold", mem_rd, 1);
      if (hold_wr) check(mem_wr && mem_wdata == hold_data, "wr_hold", mem_wdata, hold_data);
      if (mem_rd || mem_wr) check(mem_addr == exp_addr, "mem_addr", mem_addr, exp_addr);
      if (!busy) check({alu_a, alu_b, alu_mode, alu_carry_in} == 22'h0, "alu_idle", alu_a, 0);
      if (mem_wr && mem_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", mem_wdata, 0);
        end else begin
          e = exp_q.pop_front();
          check(mem_wdata == e, "write_data", mem_wdata, e);
        end
        mem[mem_addr] = mem_wdata;
        wr_idx++;
      end
      if (flags_we) begin
        check(done == 1'b1, "flags_with_done", done, 1);
        check(n_out == exp_n, "n_out", n_out, exp_n);
        check(z_out == exp_z, "z_out", z_out, exp_z);
        check(c_we == exp_cwe, "c_we", c_we, exp_cwe);
        if (exp_cwe) check(c_out == exp_c, "c_out", c_out, exp_c);
        obs_n = n_out; obs_z = z_out; obs_c = c_out; obs_cwe = c_we;
      end
      if (done) begin
        check(in_op, "unexpected_done", done, 0);
        check(cyc == exp_done_cyc, "done_cycle", cyc, exp_done_cyc);
        check(err == exp_err, "err", err, exp_err);
        check(flags_we == !exp_err, "flags_we", flags_we, !exp_err);
        last_done_cyc = cyc;
        done_seen = 1;
        in_op = 0;
      end
      hold_rd   = mem_rd && !mem_ready;
      hold_wr   = mem_wr && !mem_ready;
      hold_data = mem_wdata;
    end
  end

  task automatic prepare(input vec_t v);
    int r, c;
    bit cwe;
    model(v.op, int'(v.val), int'(v.cin), r, c, cwe);
    mem[v.addr] = v.val;
    rd_wait = v.rdw; dwr_wait = v.dww; wr_wait = v.ww;
    wr_idx = 0; stall_cnt = 0; hold_rd = 0; hold_wr = 0;
    exp_q.delete();
    exp_err = !legal(v.op);
    if (!exp_err) begin
      exp_q.push_back(v.val);
      exp_q.push_back(8'(r));
    end
    exp_n = (r >= 128); exp_z = (r == 0); exp_c = c[0]; exp_cwe = cwe;
    exp_addr = v.addr;
    exp_done_cyc = exp_err ? 1 : 5 + v.rdw + v.dww + v.ww;
    done_seen = 0;
    obs_n = 0; obs_z = 0; obs_c = 0; obs_cwe = 0;
    @(negedge clk);
    start = 1'b1; op = v.op; addr = v.addr; c_in = v.cin;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_edge = edge_cnt;
    in_op = 1;
  endtask

  task automatic run_op(input vec_t v, input bit extra);
    prepare(v);
    for (int i = 0; i < 60 && !done_seen; i++) begin
      @(negedge clk);
      if (extra && i == 1) begin
        start = 1'b1; op = DEC; addr = 16'h0300; c_in = ~v.cin;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check(done_seen, "done_timeout", done_seen, 1);
    check(mem[v.addr] == v.res, "final_mem", mem[v.addr], v.res);
    check(exp_q.size() == 0, "writes_missing", exp_q.size(), 0);
    check(last_done_cyc == v.lat, "latency", last_done_cyc, v.lat);
    if (!exp_err) begin
      check(obs_n == v.n, "lit_n", obs_n, v.n);
      check(obs_z == v.z, "lit_z", obs_z, v.z);
      check(obs_cwe == v.cwe, "lit_cwe", obs_cwe, v.cwe);
      if (v.cwe) check(obs_c == v.c, "lit_c", obs_c, v.c);
    end
    repeat (3) @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{ASL, 16'h0010, 8'h81, 1'b0, 0, 0, 0, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 5};
    vecs[1] = '{ROL, 16'h0020, 8'h80, 1'b1, 0, 0, 0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 5};
    vecs[2] = '{LSR, 16'h0021, 8'h01, 1'b0, 0, 0, 0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5};
    vecs[3] = '{INC, 16'h0022, 8'hFF, 1'b1, 0, 0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[4] = '{DEC, 16'h0023, 8'h00, 1'b0, 0, 0, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    vecs[5] = '{ROR, 16'h0024, 8'h01, 1'b1, 3, 0, 2, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 10};
    vecs[6] = '{AND, 16'h0025, 8'h55, 1'b0, 0, 0, 0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7] = '{ASL, 16'h0026, 8'h40, 1'b1, 0, 0, 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[8] = '{INC, 16'h0040, 8'h7F, 1'b0, 0, 0, 0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 5};

    reset = 1'b1; start = 1'b0; op = 5'd0; addr = 16'h0; c_in = 1'b0;
    repeat (3) @(negedge clk);
    check(({busy, done, err, mem_rd, mem_wr, flags_we, c_we, n_out, z_out, c_out} == 10'h0)
          && mem_addr == 16'h0 && mem_wdata == 8'h0 && alu_a == 8'h0 && alu_b == 8'h0
          && alu_mode == 5'h0 && alu_carry_in == 1'b0,
          "reset_state", {busy, done, mem_rd, mem_wr, flags_we}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(vecs[i], i == 7);

    // Abort in the middle of the dummy write: request must vanish without a clock edge
    begin
      vec_t rv;
      rv = '{ASL, 16'h0040, 8'h33, 1'b0, 0, 20, 0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 5};
      prepare(rv);
      for (int i = 0; i < 10 && !mem_wr; i++) @(negedge clk);
      check(mem_wr == 1'b1, "reach_dummy_wr", mem_wr, 1);
      #2;
      reset = 1'b1;
      in_op = 0; hold_rd = 0; hold_wr = 0; stall_cnt = 0;
      exp_q.delete();
      #1;
      check(mem_wr == 1'b0 && mem_rd == 1'b0, "async_bus_drop", {mem_rd, mem_wr}, 0);
      check(busy == 1'b0 && done == 1'b0 && flags_we == 1'b0, "async_idle", {busy, done, flags_we}, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check(mem[16'h0040] == 8'h33, "abort_mem_untouched", mem[16'h0040], 8'h33);
    end

    run_op(vecs[8], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
